// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with 3-sample vote, error flags and valid/ready output.
module uart_rx_frame #(
    parameter int DATA   = 8,
    parameter int PARITY = 0,
    parameter int STOP   = 1,
    parameter int OSR    = 16
) (
    input  logic            i_divided_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_rx,
    input  logic            i_ready,
    output logic [DATA-1:0] o_data,
    output logic            o_valid,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_break,
    output logic            o_overrun,
    output logic            o_busy,
    output logic [2:0]      d_state
);
    localparam int SW = $clog2(OSR);
    localparam int BW = $clog2(DATA);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;
    state_t state, state_n;
    logic rx_m, rxs, v0, v1, vote, vt, ce, fin;
    logic ferr, ferr_n, stop0_low, s0_n, brk, perr, pbit, sidx;
    logic [SW-1:0] scnt;
    logic [BW-1:0] bidx;
    logic [DATA-1:0] shreg;
    assign o_busy  = state != ST_IDLE;
    assign d_state = state;
    always_comb begin
        vote    = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
        vt      = i_en && scnt == SW'(OSR/2+1);
        ce      = i_en && scnt == SW'(OSR-1);
        fin     = state == ST_STOP && vt && sidx == 1'(STOP-1);
        ferr_n  = ferr | ~vote;
        s0_n    = sidx ? stop0_low : ~vote;
        brk     = ~|shreg & ((PARITY == 0) | ~pbit) & s0_n;
        perr    = PARITY == 0 ? 1'b0 : PARITY == 1 ? ~(^shreg ^ pbit) : (^shreg ^ pbit);
        state_n = state;
        case (state)
            ST_IDLE:  if (i_en && !rxs) state_n = ST_START;
            ST_START: if (vt && vote) state_n = ST_IDLE;
                      else if (ce) state_n = ST_DATA;
            ST_DATA:  if (ce && bidx == BW'(DATA-1)) state_n = PARITY != 0 ? ST_PAR : ST_STOP;
            ST_PAR:   if (ce) state_n = ST_STOP;
            // Completing on the vote tick leaves half a cell to catch the next start edge
            ST_STOP:  if (fin) state_n = ferr_n ? ST_WAIT : ST_IDLE;
            ST_WAIT:  if (i_en && rxs) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_divided_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else if (i_en) state <= state_n;
    end
    always_ff @(posedge i_divided_clk) begin
        if (!i_rst_n) begin
            rx_m         <= 1'b1;
            rxs          <= 1'b1;
            scnt         <= '0;
            bidx         <= '0;
            sidx         <= 1'b0;
            v0           <= 1'b0;
            v1           <= 1'b0;
            shreg        <= '0;
            pbit         <= 1'b0;
            ferr         <= 1'b0;
            stop0_low    <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            rx_m <= i_rx;
            rxs  <= rx_m;
            if (i_en) begin
                scnt <= (state == ST_IDLE || state_n == ST_IDLE || ce) ? '0 : scnt + 1'b1;
                if (scnt == SW'(OSR/2-1)) v0 <= rxs;
                if (scnt == SW'(OSR/2)) v1 <= rxs;
                if (state == ST_START) begin
                    bidx <= '0;
                    sidx <= 1'b0;
                    ferr <= 1'b0;
                end
                if (state == ST_DATA && vt) shreg[bidx] <= vote;
                if (state == ST_DATA && ce) bidx <= bidx + 1'b1;
                if (state == ST_PAR && vt) pbit <= vote;
                if (state == ST_STOP && vt) begin
                    ferr      <= ferr_n;
                    stop0_low <= s0_n;
                end
                if (state == ST_STOP && ce) sidx <= 1'b1;
            end
            // A completion while a frame is still held and not leaving is dropped
            if (fin && (!o_valid || i_ready)) begin
                o_data       <= shreg;
                o_parity_err <= perr;
                o_frame_err  <= ferr_n;
                o_break      <= brk;
                o_valid      <= 1'b1;
                o_overrun    <= 1'b0;
            end else if (fin) begin
                o_overrun <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of the 8N1 receiver and an 8E1 instance for parity.
module tb_uart_rx_frame;
    logic clk = 1'b0;
    logic rst_n, rx, rxp, ready, en;
    logic [7:0] data, p_data;
    logic valid, perr, ferr, brk, ovr, busy;
    logic p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy;
    logic [2:0] dst, p_dst;
    int per = 1;
    int div = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) div <= (div >= per - 1) ? 0 : div + 1;
    assign en = div == 0;

    uart_rx_frame dut (
        .i_divided_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx), .i_ready(ready),
        .o_data(data), .o_valid(valid), .o_parity_err(perr), .o_frame_err(ferr),
        .o_break(brk), .o_overrun(ovr), .o_busy(busy), .d_state(dst)
    );

    uart_rx_frame #(.PARITY(2)) dut_p (
        .i_divided_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rxp), .i_ready(ready),
        .o_data(p_data), .o_valid(p_valid), .o_parity_err(p_perr), .o_frame_err(p_ferr),
        .o_break(p_brk), .o_overrun(p_ovr), .o_busy(p_busy), .d_state(p_dst)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] f8(input logic [7:0] b);
        return {2'b11, b, 1'b0};
    endfunction

    task automatic send(input logic [10:0] bits, input int n, input bit p);
        for (int i = 0; i < n; i++) begin
            if (p) rxp = bits[i];
            else rx = bits[i];
            repeat (16 * per) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input bit p, input int budget);
        for (int i = 0; i < budget && !(p ? p_valid : valid); i++) begin
            @(posedge clk);
            #1;
        end
        check(p ? "p_valid_wait" : "valid_wait", p ? p_valid : valid, 1);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        rxp = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {valid, perr, ferr, brk, ovr, busy}, 0);
        check("rst_data", data, 0);
        check("rst_state", dst, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0xA5 with exact completion latency
        fork
            send(f8(8'hA5), 10, 0);
            begin
                repeat (156) @(posedge clk);
                #1;
                check("lat_before", valid, 0);
                @(posedge clk);
                #1;
                check("lat_at", valid, 1);
            end
        join
        check("a5_data", data, 8'hA5);
        check("a5_flags", {perr, ferr, brk, ovr}, 0);
        repeat (10) @(posedge clk);
        #1;
        check("a5_hold", {valid, data}, {1'b1, 8'hA5});
        accept();
        check("a5_taken", valid, 0);

        // start glitch, then 0x3C
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("glitch_start", dst, 1);
        repeat (5) @(posedge clk);
        #1;
        check("glitch_idle", dst, 0);
        check("glitch_novalid", valid, 0);
        send(f8(8'h3C), 10, 0);
        wait_valid(0, 20);
        check("3c_data", data, 8'h3C);
        check("3c_flags", {perr, ferr, brk, ovr}, 0);
        accept();

        // even parity instance
        send({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1);
        wait_valid(1, 20);
        check("par_bad_data", p_data, 8'h07);
        check("par_bad_err", {p_perr, p_ferr, p_brk}, 3'b100);
        accept();
        send({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1);
        wait_valid(1, 20);
        check("par_ok_data", p_data, 8'h07);
        check("par_ok_err", {p_perr, p_ferr, p_brk}, 0);
        accept();

        // break: line low for two frame times
        rx = 1'b0;
        wait_valid(0, 400);
        check("brk_data", data, 0);
        check("brk_flags", {perr, ferr, brk, ovr}, 4'b0110);
        accept();
        repeat (150) @(posedge clk);
        #1;
        check("brk_nomore", valid, 0);
        check("brk_wait", dst, 5);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("brk_idle", dst, 0);
        send(f8(8'h55), 10, 0);
        wait_valid(0, 20);
        check("55_data", data, 8'h55);
        check("55_flags", {perr, ferr, brk, ovr}, 0);
        accept();

        // overrun
        send(f8(8'h11), 10, 0);
        send(f8(8'h22), 10, 0);
        check("ovr_data", data, 8'h11);
        check("ovr_flags", {valid, ovr}, 2'b11);
        accept();
        check("ovr_clear", {valid, ovr}, 0);
        send(f8(8'h33), 10, 0);
        wait_valid(0, 20);
        check("33_data", data, 8'h33);
        check("33_ovr", ovr, 0);

        // reset during data bit 3 while 0x33 is still held
        send(f8(8'hA5), 4, 0);
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_state", dst, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx = 1'b1;
        check("mid_rst_flags", {valid, perr, ferr, brk, ovr, busy}, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_state", dst, 0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_quiet", valid, 0);
        send(f8(8'h81), 10, 0);
        wait_valid(0, 20);
        check("81_data", data, 8'h81);
        check("81_flags", {perr, ferr, brk, ovr}, 0);
        accept();

        // tick every third clock
        per = 3;
        repeat (6) @(posedge clk);
        #1;
        send(f8(8'hA5), 10, 0);
        wait_valid(0, 60);
        check("en3_data", data, 8'hA5);
        check("en3_flags", {perr, ferr, brk, ovr}, 0);
        accept();
        check("en3_taken", valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised successor UART receiver that runs off the divided (oversample) clock and its tick enable.
- Adds over the current receiver: configurable data width, parity and stop bits; input synchroniser; falling-edge start detection with false-start rejection; 3-sample majority vote per bit.
- Reports parity, framing, break and overrun errors.
- Presents each frame through a registered valid/ready handshake to the downstream byte consumer (Forth CPU I/O port).

Parameters:
- DATA, 8, data bits per frame, legal 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP, 1, stop bits checked, legal 1..2.
- OSR, 16, ticks per bit cell, legal even and >= 8.

Ports:
- i_divided_clk  in  1  oversample clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_en  in  1  oversample tick; state, counters and sampling advance only on edges with i_en=1.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_ready  in  1  consumer accepts the frame on an edge with o_valid=1 and i_ready=1.
- o_data  out  DATA  received data bits.
- o_valid  out  1  frame held in the output register.
- o_parity_err  out  1  parity mismatch for the held frame (always 0 when PARITY=0).
- o_frame_err  out  1  a checked stop bit voted 0 for the held frame.
- o_break  out  1  held frame had all data 0, parity bit 0 if present, and first stop bit 0.
- o_overrun  out  1  at least one frame was dropped while this frame was held.
- o_busy  out  1  state is not IDLE.
- d_state  out  3  debug state code.

Behaviour:
- Reset (edge with i_rst_n=0):
  - state IDLE; counters 0.
  - Both synchroniser flops set to 1.
  - All outputs 0, including o_data and d_state.
  - Takes effect mid-frame; the partial frame is discarded.
- Synchroniser: 2 flops on i_rx, clocked every edge regardless of i_en; rxs is the second flop's output.
- Bit timing:
  - Sample counter scnt, $clog2(OSR) bits, counts 0..OSR-1 on ticks, wraps to 0 and advances the bit.
  - Vote = majority of rxs captured at scnt = OSR/2-1, OSR/2, OSR/2+1; result is valid on the OSR/2+1 tick.
- States (d_state codes):
  - IDLE(0):
    - Tick with rxs=0 -> START, scnt=0.
    - rxs=1 -> stay.
  - START(1):
    - Vote=1 at OSR/2+1 -> IDLE (false start, no output, no flags).
    - Vote=0 -> continue.
    - scnt=OSR-1 tick -> DATA, bit index 0.
  - DATA(2):
    - Vote shifts into data bit [index].
    - End of cell: index==DATA-1 -> PARITY if PARITY!=0, else STOP; otherwise index+1.
  - PARITY(3):
    - Vote stored as parity bit.
    - Odd parity: error if XOR(data, pbit) != 1.
    - Even parity: error if XOR(data, pbit) != 0.
    - End of cell -> STOP.
  - STOP(4):
    - Vote of each stop bit checked.
    - Frame completes on the vote tick of the last stop bit, not at end of cell, so the next start edge can be caught early.
    - Completion: no stop error -> IDLE; any stop bit voted 0 -> WAIT_IDLE.
  - WAIT_IDLE(5): stays until a tick sees rxs=1 -> IDLE. Prevents a held break from retriggering.
  - Unused codes -> IDLE.
- Output register:
  - On the completion edge, o_data, o_parity_err, o_frame_err and o_break load and o_valid=1, visible the next cycle.
  - Latency: last stop-bit vote tick + 1 clock.
- Handshake and overrun:
  - Transfer edge (o_valid & i_ready): o_valid<=0 and o_overrun<=0, unless a completion occurs on the same edge.
  - Completion and transfer on the same edge: new frame loads, o_valid stays 1, o_overrun=0.
  - Completion with o_valid=1 and no transfer: new frame dropped, held contents unchanged, o_overrun<=1.
  - o_overrun clears on the transfer of the frame it is attached to.
  - Output fields stay stable while o_valid=1.
- i_en=0: no state, counter or sample change; handshake and synchroniser still operate.

Test Plan:
- 8N1, OSR=16, i_en always 1, send 0xA5 -> o_data=0xA5, all error flags 0. o_valid rises 1 clock after the stop-bit vote tick (tick 8*16+16+9 from start edge) and holds until i_ready=1, then drops next edge.
- Start glitch: i_rx low for 4 ticks then high -> returns to IDLE by scnt=9; no o_valid; a following 0x3C frame is received correctly.
- PARITY=2, send 0x07 with parity bit 0 -> o_parity_err=1, o_data=0x07. Same frame with parity bit 1 -> o_parity_err=0.
- Line held low for 2 frame times -> one frame with o_data=0x00, o_frame_err=1, o_break=1; no further frames until i_rx high. After return high, a 0x55 frame is received with no flags.
- i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun=1. After accept, o_valid=0 and o_overrun=0. Third frame 0x33 delivered normally.
- Reset (i_rst_n=0 for 1 clock) during DATA bit 3 -> all outputs 0, d_state=0 next cycle; a subsequent 0x81 frame is received correctly. Repeat the 0xA5 case with i_en high every 3rd clock -> same data and flags.
